trans_reader: RTL and testbench

- Egress-side consumer for the transaction layer's four destination FIFOs.
- Drains the FIFOs round-robin through their pop/valid interface and merges the words into one output stream, tagged with the source channel, using a valid/ready handshake.
- Keeps per-channel delivered-word counters, read through the same req/idx scheme the layer's contador uses.
- Sits between the layer's data_out0..3 outputs and the downstream sink or bench.

---
 rtl/trans_pkg.sv | 18 +
 rtl/trans_reader_if.sv | 45 ++++
 rtl/rr_select.sv | 23 ++
 rtl/trans_reader.sv | 154 +++++++++++++++
 tb/tb_trans_reader.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/trans_pkg.sv
// Shared constants and FSM encoding for the transaction-layer egress reader.
package trans_pkg;

    localparam int unsigned DEF_DATA_SIZE = 12;
    localparam int unsigned DEF_IDX_SIZE  = 3;
    localparam int unsigned DEF_CNT_SIZE  = 6;
    localparam int unsigned NUM_CH        = 4;
    // Counter-select index that returns the all-channel total.
    localparam int unsigned IDX_TOTAL     = 4;

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_IDLE    = 2'd1,
        ST_POP     = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

endpackage

// File: rtl/trans_reader_if.sv
// FIFO pop/valid side, merged output stream and counter-read port of trans_reader.
interface trans_reader_if #(
    parameter int unsigned DATA_SIZE = trans_pkg::DEF_DATA_SIZE,
    parameter int unsigned IDX_SIZE  = trans_pkg::DEF_IDX_SIZE,
    parameter int unsigned CNT_SIZE  = trans_pkg::DEF_CNT_SIZE
) ();

    logic                 init;
    logic                 fifo_empty0, fifo_empty1, fifo_empty2, fifo_empty3;
    logic [DATA_SIZE-1:0] data_in0, data_in1, data_in2, data_in3;
    logic                 valid_in0, valid_in1, valid_in2, valid_in3;
    logic                 pop0, pop1, pop2, pop3;
    logic [DATA_SIZE-1:0] data_out;
    logic [1:0]           chan_out;
    logic                 valid_out;
    logic                 sink_ready;
    logic                 req;
    logic [IDX_SIZE-1:0]  idx;
    logic [CNT_SIZE-1:0]  cnt_out;
    logic                 cnt_valid;
    logic                 err;

    modport master (
        input  init,
        input  fifo_empty0, fifo_empty1, fifo_empty2, fifo_empty3,
        input  data_in0, data_in1, data_in2, data_in3,
        input  valid_in0, valid_in1, valid_in2, valid_in3,
        input  sink_ready, req, idx,
        output pop0, pop1, pop2, pop3,
        output data_out, chan_out, valid_out,
        output cnt_out, cnt_valid, err
    );

    modport slave (
        output init,
        output fifo_empty0, fifo_empty1, fifo_empty2, fifo_empty3,
        output data_in0, data_in1, data_in2, data_in3,
        output valid_in0, valid_in1, valid_in2, valid_in3,
        output sink_ready, req, idx,
        input  pop0, pop1, pop2, pop3,
        input  data_out, chan_out, valid_out,
        input  cnt_out, cnt_valid, err
    );

endinterface

// File: rtl/rr_select.sv
// Combinational 4-way round-robin picker: first requester after 'last', modulo 4.
module rr_select (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] grant,
    output logic       any
);

    logic [1:0] cand;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant = last;
        cand  = last;
        for (int i = 4; i >= 1; i--) begin
            cand = last + 2'(i);
            if (req[cand]) grant = cand;
        end
    end

    assign any = |req;

endmodule

// File: rtl/trans_reader.sv
// Round-robin drain of four destination FIFOs into one channel-tagged valid/ready
// stream, with per-channel and total delivered-word counters.
module trans_reader
    import trans_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
    parameter int unsigned IDX_SIZE  = DEF_IDX_SIZE,
    parameter int unsigned CNT_SIZE  = DEF_CNT_SIZE
) (
    input logic            clk,
    input logic            reset_L,
    trans_reader_if.master bus
);

    logic [NUM_CH-1:0]    nonempty;
    logic [NUM_CH-1:0]    vin;
    logic [DATA_SIZE-1:0] din [NUM_CH];

    assign nonempty = ~{bus.fifo_empty3, bus.fifo_empty2, bus.fifo_empty1, bus.fifo_empty0};
    assign vin      = {bus.valid_in3, bus.valid_in2, bus.valid_in1, bus.valid_in0};
    assign din[0]   = bus.data_in0;
    assign din[1]   = bus.data_in1;
    assign din[2]   = bus.data_in2;
    assign din[3]   = bus.data_in3;

    state_t               state, state_nx;
    logic [1:0]           rr_last, rr_last_nx;
    logic [1:0]           sel, sel_nx;
    logic [NUM_CH-1:0]    pop, pop_nx;
    logic                 valid_q, valid_nx;
    logic [DATA_SIZE-1:0] data_q, data_nx;
    logic [1:0]           chan_q, chan_nx;
    logic                 err_q, err_nx;
    logic [CNT_SIZE-1:0]  cnt_out_q, cnt_out_nx;
    logic                 cnt_valid_q, cnt_valid_nx;
    logic [CNT_SIZE-1:0]  cnt [NUM_CH];
    logic [CNT_SIZE-1:0]  total;
    logic [1:0]           grant;
    logic                 any;
    logic                 handshake;

    assign handshake = valid_q && bus.sink_ready;

    rr_select u_rr (
        .req   (nonempty),
        .last  (rr_last),
        .grant (grant),
        .any   (any)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_nx     = state;
        rr_last_nx   = rr_last;
        sel_nx       = sel;
        pop_nx       = '0;
        valid_nx     = valid_q && !bus.sink_ready;
        data_nx      = data_q;
        chan_nx      = chan_q;
        err_nx       = err_q;
        cnt_out_nx   = cnt_out_q;
        cnt_valid_nx = 1'b0;

        case (state)
            ST_RESET: begin
                if (bus.init) state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                // A slot being accepted this edge counts as free.
                if (any && (!valid_q || bus.sink_ready)) begin
                    pop_nx[grant] = 1'b1;
                    sel_nx        = grant;
                    rr_last_nx    = grant;
                    state_nx      = ST_POP;
                end
            end
            ST_POP: begin
                state_nx = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_nx = ST_IDLE;
                if (vin[sel]) begin
                    data_nx  = din[sel];
                    chan_nx  = sel;
                    valid_nx = 1'b1;
                end else begin
                    err_nx = 1'b1;
                end
            end
            default: state_nx = ST_RESET;
        endcase

        if (state != ST_RESET && bus.req) begin
            if (bus.idx < IDX_SIZE'(IDX_TOTAL)) begin
                cnt_out_nx   = cnt[bus.idx[1:0]];
                cnt_valid_nx = 1'b1;
            end else if (bus.idx == IDX_SIZE'(IDX_TOTAL)) begin
                cnt_out_nx   = total;
                cnt_valid_nx = 1'b1;
            end else begin
                cnt_out_nx = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state       <= ST_RESET;
            rr_last     <= 2'd3;
            sel         <= 2'd0;
            pop         <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            chan_q      <= 2'd0;
            err_q       <= 1'b0;
            cnt_out_q   <= '0;
            cnt_valid_q <= 1'b0;
        end else begin
            state       <= state_nx;
            rr_last     <= rr_last_nx;
            sel         <= sel_nx;
            pop         <= pop_nx;
            valid_q     <= valid_nx;
            data_q      <= data_nx;
            chan_q      <= chan_nx;
            err_q       <= err_nx;
            cnt_out_q   <= cnt_out_nx;
            cnt_valid_q <= cnt_valid_nx;
        end
    end

    // Delivered-word counters advance on each accepted handshake; wrap silently.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int k = 0; k < int'(NUM_CH); k++) cnt[k] <= '0;
            total <= '0;
        end else if (handshake) begin
            cnt[chan_q] <= cnt[chan_q] + CNT_SIZE'(1);
            total       <= total + CNT_SIZE'(1);
        end
    end

    assign bus.pop0      = pop[0];
    assign bus.pop1      = pop[1];
    assign bus.pop2      = pop[2];
    assign bus.pop3      = pop[3];
    assign bus.data_out  = data_q;
    assign bus.chan_out  = chan_q;
    assign bus.valid_out = valid_q;
    assign bus.cnt_out   = cnt_out_q;
    assign bus.cnt_valid = cnt_valid_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_trans_reader.sv
// Directed bench for trans_reader with a small behavioural model of the four FIFOs.
module tb_trans_reader;

    logic clk;
    logic reset_L;
    int   n_assert = 0;
    int   n_fail   = 0;

    trans_reader_if bus ();

    trans_reader dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: valid_in follows a sampled pop by one cycle; flushed while in reset.
    logic [11:0] mem [4][128];
    logic [6:0]  rd [4];
    logic [6:0]  wr [4];
    logic [11:0] dq [4];
    logic [3:0]  vq;
    logic        kill_v0;
    logic [3:0]  pops;

    assign pops = {bus.pop3, bus.pop2, bus.pop1, bus.pop0};

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!reset_L) begin
                rd[k] <= wr[k];
                dq[k] <= '0;
                vq[k] <= 1'b0;
            end else begin
                vq[k] <= 1'b0;
                if (pops[k] && rd[k] != wr[k]) begin
                    dq[k] <= mem[k][rd[k]];
                    vq[k] <= !(k == 0 && kill_v0);
                    rd[k] <= rd[k] + 7'd1;
                end
            end
        end
    end

    assign bus.fifo_empty0 = (rd[0] == wr[0]);
    assign bus.fifo_empty1 = (rd[1] == wr[1]);
    assign bus.fifo_empty2 = (rd[2] == wr[2]);
    assign bus.fifo_empty3 = (rd[3] == wr[3]);
    assign bus.data_in0    = dq[0];
    assign bus.data_in1    = dq[1];
    assign bus.data_in2    = dq[2];
    assign bus.data_in3    = dq[3];
    assign bus.valid_in0   = vq[0];
    assign bus.valid_in1   = vq[1];
    assign bus.valid_in2   = vq[2];
    assign bus.valid_in3   = vq[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input logic [11:0] v);
        mem[k][wr[k]] = v;
        wr[k] = wr[k] + 7'd1;
    endtask

    // Wait (bounded) for a word, check it, then let the sink accept it.
    task automatic expect_word(input string tag, input logic [11:0] d, input logic [1:0] c);
        int n;
        n = 0;
        while (bus.valid_out !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(bus.valid_out), 32'd1);
        check({tag, "_data"},  32'(bus.data_out),  32'(d));
        check({tag, "_chan"},  32'(bus.chan_out),  32'(c));
        @(negedge clk);
    endtask

    task automatic read_cnt(input string tag, input logic [2:0] i, input logic [5:0] exp,
                            input logic expv);
        bus.req = 1'b1;
        bus.idx = i;
        @(negedge clk);
        bus.req = 1'b0;
        check({tag, "_cnt"},   32'(bus.cnt_out),   32'(exp));
        check({tag, "_vld"},   32'(bus.cnt_valid), 32'(expv));
        @(negedge clk);
        check({tag, "_pulse"}, 32'(bus.cnt_valid), 32'd0);
    endtask

    always @(negedge clk) begin
        n_assert++;
        assert ($onehot0(pops)) else begin
            n_fail++;
            $error("FAIL pop_onehot: observed %b expected at most one bit set", pops);
        end
    end

    logic [1:0]  rr_ch [8] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    logic [11:0] rr_d  [8] = '{12'h130, 12'h100, 12'h110, 12'h120,
                               12'h131, 12'h101, 12'h111, 12'h121};

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        reset_L        = 1'b0;
        bus.init       = 1'b0;
        bus.sink_ready = 1'b0;
        bus.req        = 1'b0;
        bus.idx        = 3'd0;
        kill_v0        = 1'b0;
        for (int k = 0; k < 4; k++) wr[k] = 7'd0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_pop",       32'(pops),          32'd0);
        check("rst_valid",     32'(bus.valid_out), 32'd0);
        check("rst_data",      32'(bus.data_out),  32'd0);
        check("rst_chan",      32'(bus.chan_out),  32'd0);
        check("rst_cnt_out",   32'(bus.cnt_out),   32'd0);
        check("rst_cnt_valid", 32'(bus.cnt_valid), 32'd0);
        check("rst_err",       32'(bus.err),       32'd0);

        // Out of reset but no init: pops and counter reads are ignored
        reset_L = 1'b1;
        push(0, 12'h3C1);
        bus.req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("noinit_pop",   32'(pops),          32'd0);
            check("noinit_cnt_v", 32'(bus.cnt_valid), 32'd0);
            check("noinit_valid", 32'(bus.valid_out), 32'd0);
        end
        bus.req  = 1'b0;
        bus.init = 1'b1;
        @(negedge clk);
        bus.init = 1'b0;
        check("init_idle_pop", 32'(pops), 32'd0);
        @(negedge clk);
        check("init_pop0", 32'(pops), 32'b0001);
        @(negedge clk);
        check("init_pop_clr", 32'(pops), 32'd0);
        @(negedge clk);
        check("w0_valid", 32'(bus.valid_out), 32'd1);
        check("w0_data",  32'(bus.data_out),  32'h3C1);
        check("w0_chan",  32'(bus.chan_out),  32'd0);

        // Backpressure: word held, no pops while the slot is full
        push(1, 12'h111);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("bp_pop",   32'(pops),          32'd0);
            check("bp_valid", 32'(bus.valid_out), 32'd1);
            check("bp_data",  32'(bus.data_out),  32'h3C1);
        end
        bus.sink_ready = 1'b1;
        @(negedge clk);
        check("bp_resume_pop", 32'(pops),          32'b0010);
        check("bp_accepted",   32'(bus.valid_out), 32'd0);
        expect_word("bp_w1", 12'h111, 2'd1);

        // Single word on FIFO2
        push(2, 12'hA5C);
        @(negedge clk);
        check("sw_pop2", 32'(pops), 32'b0100);
        @(negedge clk);
        check("sw_pop_clr", 32'(pops), 32'd0);
        @(negedge clk);
        check("sw_valid", 32'(bus.valid_out), 32'd1);
        check("sw_data",  32'(bus.data_out),  32'hA5C);
        check("sw_chan",  32'(bus.chan_out),  32'd2);
        @(negedge clk);

        // Round robin, last grant was channel 2
        for (int k = 0; k < 4; k++) begin
            push(k, 12'(12'h100 + k * 16));
            push(k, 12'(12'h101 + k * 16));
        end
        for (int i = 0; i < 8; i++) expect_word($sformatf("rr%0d", i), rr_d[i], rr_ch[i]);

        // Missing valid_in during CAPTURE sets sticky err
        kill_v0 = 1'b1;
        push(0, 12'hBAD);
        @(negedge clk);
        check("err_pop0", 32'(pops), 32'b0001);
        @(negedge clk);
        check("err_pop_clr", 32'(pops), 32'd0);
        @(negedge clk);
        check("err_set",   32'(bus.err),       32'd1);
        check("err_noval", 32'(bus.valid_out), 32'd0);
        kill_v0 = 1'b0;
        push(0, 12'hBEE);
        @(negedge clk);
        check("mid_pop0",   32'(pops),    32'b0001);
        check("err_sticky", 32'(bus.err), 32'd1);

        // Reset while in POP
        reset_L = 1'b0;
        #1;
        check("mid_rst_pop",   32'(pops),          32'd0);
        check("mid_rst_err",   32'(bus.err),       32'd0);
        check("mid_rst_valid", 32'(bus.valid_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_L  = 1'b1;
        bus.init = 1'b1;
        @(negedge clk);
        bus.init = 1'b0;
        read_cnt("mid_rst_c0", 3'd0, 6'd0, 1'b1);
        read_cnt("mid_rst_tot", 3'd4, 6'd0, 1'b1);

        // Counters: 3 words on ch1, 1 on ch3
        push(1, 12'h1A1);
        push(1, 12'h1A2);
        push(1, 12'h1A3);
        push(3, 12'h3D1);
        expect_word("c_a", 12'h1A1, 2'd1);
        expect_word("c_b", 12'h3D1, 2'd3);
        expect_word("c_c", 12'h1A2, 2'd1);
        begin
            int n;
            n = 0;
            while (bus.valid_out !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("c_d_data", 32'(bus.data_out), 32'h1A3);
        check("c_d_chan", 32'(bus.chan_out), 32'd1);
        // Read on the same edge as the increment returns the old value
        bus.req = 1'b1;
        bus.idx = 3'd1;
        @(negedge clk);
        bus.req = 1'b0;
        check("pre_inc_cnt", 32'(bus.cnt_out),   32'd2);
        check("pre_inc_vld", 32'(bus.cnt_valid), 32'd1);
        @(negedge clk);
        read_cnt("cnt1", 3'd1, 6'd3, 1'b1);
        read_cnt("cnt3", 3'd3, 6'd1, 1'b1);
        read_cnt("tot",  3'd4, 6'd4, 1'b1);
        read_cnt("idx6", 3'd6, 6'd0, 1'b0);

        // Wrap: 63 words on ch0, then one more
        for (int i = 0; i < 63; i++) push(0, 12'(i * 3 + 1));
        for (int i = 0; i < 63; i++) expect_word($sformatf("wrap%0d", i), 12'(i * 3 + 1), 2'd0);
        read_cnt("cnt0_63", 3'd0, 6'd63, 1'b1);
        read_cnt("tot_67",  3'd4, 6'd3,  1'b1);
        push(0, 12'hFFF);
        expect_word("wrap63", 12'hFFF, 2'd0);
        read_cnt("cnt0_wrap", 3'd0, 6'd0, 1'b1);
        read_cnt("tot_68",    3'd4, 6'd4, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
